// File: rtl/alu_issue_seq_if.sv
// Request / ALU / response bundle between an issuing sequencer and its environment.
// The slave modport is the sequencer's view; the master is the requester, ALU and consumer.
interface alu_issue_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_instr;
  logic [31:0] req_rs1_val;
  logic [31:0] req_rs2_val;

  logic [2:0]  alu_opcode;
  logic [31:0] alu_op_0;
  logic [31:0] alu_op_1;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        alu_negative;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  logic        rsp_we;
  logic        rsp_illegal;
  logic        rsp_zero;

  modport slave (
    input  req_valid, req_instr, req_rs1_val, req_rs2_val,
    input  alu_out, alu_zero, alu_negative,
    input  rsp_ready,
    output req_ready,
    output alu_opcode, alu_op_0, alu_op_1,
    output rsp_valid, rsp_rd, rsp_data, rsp_we, rsp_illegal, rsp_zero
  );

  modport master (
    output req_valid, req_instr, req_rs1_val, req_rs2_val,
    output alu_out, alu_zero, alu_negative,
    output rsp_ready,
    input  req_ready,
    input  alu_opcode, alu_op_0, alu_op_1,
    input  rsp_valid, rsp_rd, rsp_data, rsp_we, rsp_illegal, rsp_zero
  );
endinterface

// File: rtl/alu_issue_seq.sv
// Issues one RV32I OP/OP-IMM instruction to a registered-latency ALU and returns a
// writeback response; SLT/SLTU are derived from an ALU SUB plus its NEGATIVE flag.
module alu_issue_seq #(
  parameter int ALU_LATENCY = 1
) (
  input logic          clock,
  input logic          reset,
  alu_issue_seq_if.slave bus
);

  localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LATENCY - 1);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {KIND_ALU, KIND_SLT, KIND_SLTU} kind_t;

  // Less-than from a SUB: differing sign bits decide directly (overflow-free),
  // otherwise the sign of the difference is the answer.
  function automatic logic set_less(input kind_t kind, input logic [31:0] a,
                                    input logic [31:0] b, input logic neg);
    if (a[31] != b[31])
      return (kind == KIND_SLT) ? a[31] : b[31];
    return neg;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] lat_cnt;
  kind_t            kind_p1;
  logic [4:0]       rd_p1;
  logic [2:0]       alu_opcode_q;
  logic [31:0]      alu_op_0_q;
  logic [31:0]      alu_op_1_q;
  logic             rsp_valid_q;
  logic [4:0]       rsp_rd_q;
  logic [31:0]      rsp_data_q;
  logic             rsp_we_q;
  logic             rsp_illegal_q;
  logic             rsp_zero_q;

  logic [6:0]         opc_p0;
  logic [6:0]         f7_p0;
  logic [2:0]         f3_p0;
  logic               is_r_p0;
  logic               is_i_p0;
  logic               alt_p0;
  logic               illegal_p0;
  logic [2:0]         aluop_p0;
  kind_t              kind_p0;
  logic [31:0]        op1_p0;
  logic signed [31:0] imm_p0;
  logic               unused_rs_fields;

  assign opc_p0  = bus.req_instr[6:0];
  assign f3_p0   = bus.req_instr[14:12];
  assign f7_p0   = bus.req_instr[31:25];
  assign is_r_p0 = (opc_p0 == OPC_OP);
  assign is_i_p0 = (opc_p0 == OPC_OPIMM);
  assign alt_p0  = (f7_p0 == F7_ALT);
  assign imm_p0  = {{20{bus.req_instr[31]}}, bus.req_instr[31:20]};

  // Register specifiers arrive already resolved into req_rs1_val / req_rs2_val.
  assign unused_rs_fields = ^bus.req_instr[19:15];

  // Decode stage: classify, choose ALU opcode and second operand
  always_comb begin
    illegal_p0 = !(is_r_p0 || is_i_p0);
    aluop_p0   = ALU_ADD;
    kind_p0    = KIND_ALU;
    op1_p0     = bus.req_rs2_val;

    if (is_r_p0 && (f7_p0 != F7_BASE) && !alt_p0)
      illegal_p0 = 1'b1;
    if (is_r_p0 && alt_p0 && (f3_p0 != 3'b000) && (f3_p0 != 3'b101))
      illegal_p0 = 1'b1;
    if (is_i_p0 && (f3_p0 == 3'b001) && (f7_p0 != F7_BASE))
      illegal_p0 = 1'b1;
    if (is_i_p0 && (f3_p0 == 3'b101) && (f7_p0 != F7_BASE) && !alt_p0)
      illegal_p0 = 1'b1;

    case (f3_p0)
      3'b000: aluop_p0 = (is_r_p0 && alt_p0) ? ALU_SUB : ALU_ADD;
      3'b001: aluop_p0 = ALU_SLL;
      3'b010: begin
        aluop_p0 = ALU_SUB;
        kind_p0  = KIND_SLT;
      end
      3'b011: begin
        aluop_p0 = ALU_SUB;
        kind_p0  = KIND_SLTU;
      end
      3'b100: aluop_p0 = ALU_XOR;
      3'b101: aluop_p0 = alt_p0 ? ALU_SRA : ALU_SRL;
      3'b110: aluop_p0 = ALU_OR;
      default: aluop_p0 = ALU_AND;
    endcase

    if (is_i_p0) begin
      if ((f3_p0 == 3'b001) || (f3_p0 == 3'b101))
        op1_p0 = {27'b0, bus.req_instr[24:20]};
      else
        op1_p0 = imm_p0;
    end
  end

  // Sequencing stage: accept, issue, wait out ALU latency, capture, respond
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      kind_p1       <= KIND_ALU;
      rd_p1         <= '0;
      alu_opcode_q  <= '0;
      alu_op_0_q    <= '0;
      alu_op_1_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rd_q      <= '0;
      rsp_data_q    <= '0;
      rsp_we_q      <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_zero_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (illegal_p0) begin
              rsp_rd_q      <= bus.req_instr[11:7];
              rsp_data_q    <= '0;
              rsp_we_q      <= 1'b0;
              rsp_illegal_q <= 1'b1;
              rsp_zero_q    <= 1'b0;
              rsp_valid_q   <= 1'b1;
              state         <= DONE;
            end else begin
              alu_opcode_q <= aluop_p0;
              alu_op_0_q   <= bus.req_rs1_val;
              alu_op_1_q   <= op1_p0;
              rd_p1        <= bus.req_instr[11:7];
              kind_p1      <= kind_p0;
              state        <= ISSUE;
            end
          end
        end
        ISSUE: begin
          lat_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == CNT_LAST) begin
            if (kind_p1 == KIND_ALU)
              rsp_data_q <= bus.alu_out;
            else
              rsp_data_q <= {31'b0, set_less(kind_p1, alu_op_0_q, alu_op_1_q,
                                             bus.alu_negative)};
            rsp_zero_q    <= bus.alu_zero;
            rsp_rd_q      <= rd_p1;
            rsp_we_q      <= (rd_p1 != 5'd0);
            rsp_illegal_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state         <= DONE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state == IDLE) && !reset;
  assign bus.alu_opcode  = alu_opcode_q;
  assign bus.alu_op_0    = alu_op_0_q;
  assign bus.alu_op_1    = alu_op_1_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rd      = rsp_rd_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_we      = rsp_we_q;
  assign bus.rsp_illegal = rsp_illegal_q;
  assign bus.rsp_zero    = rsp_zero_q;

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Initiator side of the ALU operand/result interface.
- Accepts one decoded RV32I OP/OP-IMM instruction with its register values over a valid/ready handshake.
- Drives the ALU's opcode and operand inputs, waits out the ALU's registered latency, then captures out/ZERO/NEGATIVE.
- Presents a writeback response. SLT/SLTU are synthesised from an ALU SUB plus the NEGATIVE flag.

Parameters:
ALU_LATENCY, 1, number of clock edges from operands stable at ALU inputs to alu_out/flags valid (>=1)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept request
req_instr  input  32  RV32I instruction word
req_rs1_val  input  32  rs1 value
req_rs2_val  input  32  rs2 value (ignored for OP-IMM)
alu_opcode  output  3  to ALU opcode (ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLL 101, SRL 110, SRA 111)
alu_op_0  output  32  to ALU op_0
alu_op_1  output  32  to ALU op_1
alu_out  input  32  ALU result
alu_zero  input  1  ALU ZERO flag
alu_negative  input  1  ALU NEGATIVE flag
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_rd  output  5  destination register
rsp_data  output  32  writeback value
rsp_we  output  1  write enable (0 if rd==0 or illegal)
rsp_illegal  output  1  instruction not a legal OP/OP-IMM

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset puts the FSM in IDLE, clears the latency counter, and drives all registered outputs to 0.
- Reset asserted in any state aborts the in-flight operation; no response is produced for it.
- req_ready = 1 only in IDLE and reset low. The request is accepted on the rising edge with req_valid & req_ready.
- Decode on accept:
  - opcode 0110011 = R-type; 0010011 = I-type.
  - I-type op_1 = sign-extended instr[31:20]; shifts use {27'b0, instr[24:20]}.
  - funct3 mapping: 000 ADD (SUB if R-type and funct7=0100000); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA if funct7=0100000; 110 OR; 111 AND.
  - SLT and SLTU issue alu_opcode SUB.
- Illegal cases:
  - any other opcode;
  - R-type funct7 not 0000000/0100000;
  - funct7=0100000 with funct3 other than 000/101;
  - I-type funct3 001/101 with funct7 not 0000000 (or 0100000 for 101).
- On an illegal instruction: go straight to DONE. rsp_illegal=1, rsp_we=0, rsp_data=0, rsp_rd=instr[11:7]. ALU outputs are not changed.
- Legal path:
  - Accept edge registers alu_opcode/op_0/op_1, rd and the op kind, then moves to ISSUE.
  - ISSUE lasts 1 cycle, then WAIT.
  - WAIT counts ALU_LATENCY-1 further cycles; on its final edge, alu_out/flags are captured and the FSM moves to DONE.
  - With ALU_LATENCY=1: accept at edge N, capture at edge N+2, rsp_valid high from after edge N+2.
- ALU outputs hold stable from accept through the capture edge.
- Result selection:
  - normal ops: rsp_data = alu_out.
  - SLT: if op_0[31] != op_1[31], result = op_0[31]; else result = alu_negative.
  - SLTU: if op_0[31] != op_1[31], result = op_1[31]; else result = alu_negative.
  - SLT/SLTU write {31'b0, result}.
- rsp_we = legal & (rd != 0). The ALU is still exercised when rd==0.
- DONE holds rsp_* stable while rsp_ready=0. On the rsp_valid & rsp_ready edge: return to IDLE and drop rsp_valid. The next request is accepted no earlier than the following edge; there is no same-cycle turnaround.
- alu_zero is captured but unused except by the bench.

Test Plan:
- ADD x3,x1,x2 with rs1=5, rs2=7 -> alu_opcode=000, rsp_data=0x0000000C, rsp_rd=3, rsp_we=1, rsp_valid 2 edges after accept.
- SUB with rs1=5, rs2=7 -> alu_opcode=001, rsp_data=0xFFFFFFFE.
- SLT rs1=0x80000000, rs2=1 -> rsp_data=1. SLTU same operands -> rsp_data=0. SLT 3 vs 3 -> 0.
- SRAI rd=4, shamt=4, rs1=0xF0000000 -> op_1=4, alu_opcode=111, rsp_data=0xFF000000. ADDI imm=0xFFF, rs1=1 -> rsp_data=0.
- R-type funct7=0000001 -> rsp_illegal=1, rsp_we=0 one edge after accept, ALU outputs unchanged. ADD to x0 -> rsp_we=0.
- Backpressure: hold rsp_ready=0 for 3 cycles -> rsp_* stable and req_ready=0 throughout. Reset asserted during WAIT -> IDLE next edge, rsp_valid stays 0, no response for the aborted op.
